// File: rtl/mega_demux_scatter_pkg.sv
// Shared constants for the byte scatter unit.
//   DEF_WIDTH / DEF_LANES / DEF_SELW : default lane width, lane count and select width
//   ST_IDLE / ST_FILL / ST_DONE      : frame-fill FSM encodings
package mega_demux_scatter_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_LANES = 16;
  localparam int DEF_SELW  = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mega_demux_scatter_lane.sv
// One scatter lane: a WIDTH-bit data register plus its full flag.
//   Clk, Rst : clock, synchronous active-high reset
//   wr_en    : store wr_data and mark the lane full
//   wr_data  : byte to store
//   ack      : consumer ack, clears the full flag (a same-cycle write wins)
//   data     : stored byte (never cleared by ack)
//   full     : lane holds an unconsumed byte
module mega_demux_scatter_lane #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             ack,
  output logic [WIDTH-1:0] data,
  output logic             full
);

  // NOTE: the data register is reset along with the flag because the whole
  // bus is defined as zero after reset, not just the full bits.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      data <= '0;
      full <= 1'b0;
    end else if (wr_en) begin
      data <= wr_data;
      full <= 1'b1;
    end else if (ack) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/mega_demux_scatter.sv
// 1-to-16 byte scatter unit. Accepts one byte per valid/ready handshake and
// stores it in a lane chosen directly (In_Sel) or by an auto-sequenced frame
// fill that walks lanes 0..LANES-1.
//   Clk, Rst    : clock, synchronous active-high reset
//   In_Data     : byte to store
//   In_Sel      : target lane in direct mode
//   In_Valid    : In_Data/In_Sel valid this cycle
//   In_Ready    : unit can accept this cycle (combinational)
//   Start       : begin an auto frame fill (ignored unless idle)
//   Lane_Ack    : per-lane consumer ack
//   Lane_Full   : per-lane unconsumed-byte flag
//   Out_Bus     : lane i at [i*WIDTH +: WIDTH]
//   Busy        : auto frame in progress
//   Frame_Done  : one-cycle pulse after the last lane of a frame is written
module mega_demux_scatter
  import mega_demux_scatter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = DEF_LANES,
  parameter int SELW  = DEF_SELW
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [WIDTH-1:0]       In_Data,
  input  logic [SELW-1:0]        In_Sel,
  input  logic                   In_Valid,
  output logic                   In_Ready,
  input  logic                   Start,
  input  logic [LANES-1:0]       Lane_Ack,
  output logic [LANES-1:0]       Lane_Full,
  output logic [WIDTH*LANES-1:0] Out_Bus,
  output logic                   Busy,
  output logic                   Frame_Done
);

  logic [1:0]       state;
  logic [SELW-1:0]  counter;
  logic [SELW-1:0]  target;
  logic             accept;
  logic [LANES-1:0] lane_wr;

  assign target = (state == ST_FILL) ? counter : In_Sel;

  // A full lane can still take a byte in the cycle its consumer acks it.
  assign In_Ready = !Rst && (state != ST_DONE) &&
                    (!Lane_Full[target] || Lane_Ack[target]);
  assign accept   = In_Valid && In_Ready;

  // NOTE: default the whole vector first so the indexed write below cannot
  // leave any bit unassigned and infer a latch.
  always_comb begin
    lane_wr         = '0;
    lane_wr[target] = accept;
  end

  // NOTE: state registers use non-blocking assignments so every flop in the
  // block samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= ST_IDLE;
      counter <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // A byte offered alongside Start goes to In_Sel; the frame starts next cycle.
          if (Start) begin
            state   <= ST_FILL;
            counter <= '0;
          end
        end
        ST_FILL: begin
          // A stall on a full lane simply holds the counter.
          if (accept) begin
            counter <= counter + SELW'(1);
            if (counter == SELW'(LANES - 1)) state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign Busy       = (state == ST_FILL);
  assign Frame_Done = (state == ST_DONE);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mega_demux_scatter_lane #(.WIDTH(WIDTH)) u_lane (
      .Clk     (Clk),
      .Rst     (Rst),
      .wr_en   (lane_wr[i]),
      .wr_data (In_Data),
      .ack     (Lane_Ack[i]),
      .data    (Out_Bus[i*WIDTH +: WIDTH]),
      .full    (Lane_Full[i])
    );
  end

endmodule

// File: tb/tb_mega_demux_scatter.sv
// Self-checking bench for mega_demux_scatter: directed scenarios followed by
// randomized traffic, all compared against a lane-array reference model.
module tb_mega_demux_scatter;

  localparam int W = 8;
  localparam int L = 16;
  localparam int S = 4;

  logic           Clk = 1'b0;
  logic           Rst;
  logic [W-1:0]   In_Data;
  logic [S-1:0]   In_Sel;
  logic           In_Valid;
  logic           In_Ready;
  logic           Start;
  logic [L-1:0]   Lane_Ack;
  logic [L-1:0]   Lane_Full;
  logic [W*L-1:0] Out_Bus;
  logic           Busy;
  logic           Frame_Done;

  always #5 Clk = ~Clk;

  mega_demux_scatter dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .In_Data    (In_Data),
    .In_Sel     (In_Sel),
    .In_Valid   (In_Valid),
    .In_Ready   (In_Ready),
    .Start      (Start),
    .Lane_Ack   (Lane_Ack),
    .Lane_Full  (Lane_Full),
    .Out_Bus    (Out_Bus),
    .Busy       (Busy),
    .Frame_Done (Frame_Done)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: what each lane holds, whether it is full, and where the
  // running frame (if any) will write next.
  logic [W-1:0] m_data[L];
  bit           m_full[L];
  bit           m_frame;
  int           m_next;
  bit           m_done;
  bit           last_stall;
  int           done_pulses;

  task automatic check(input string tag, input logic [W*L-1:0] obs, input logic [W*L-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W*L-1:0] model_bus();
    logic [W*L-1:0] b;
    for (int i = 0; i < L; i++) b[i*W +: W] = m_data[i];
    return b;
  endfunction

  function automatic logic [L-1:0] model_full();
    logic [L-1:0] f;
    for (int i = 0; i < L; i++) f[i] = m_full[i];
    return f;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < L; i++) begin
      m_data[i] = '0;
      m_full[i] = 1'b0;
    end
    m_frame = 1'b0;
    m_next  = 0;
    m_done  = 1'b0;
  endtask

  task automatic quiet();
    Rst      = 1'b0;
    In_Valid = 1'b0;
    Start    = 1'b0;
    Lane_Ack = '0;
  endtask

  // One clock: check the handshake before the edge, advance the model with
  // the inputs presented, then check all registered outputs after the edge.
  task automatic step();
    int t;
    bit rdy;
    bit acc;
    #1;
    t   = m_frame ? m_next : int'(In_Sel);
    rdy = !Rst && !m_done && (!m_full[t] || Lane_Ack[t]);
    check("in_ready", {127'b0, In_Ready}, {127'b0, rdy});
    acc = In_Valid && rdy;
    last_stall = In_Valid && !rdy;
    @(posedge Clk);
    if (Rst) begin
      model_clear();
    end else begin
      for (int i = 0; i < L; i++) begin
        if (acc && i == t) begin
          m_data[i] = In_Data;
          m_full[i] = 1'b1;
        end else if (Lane_Ack[i]) begin
          m_full[i] = 1'b0;
        end
      end
      if (m_done) begin
        m_done = 1'b0;
      end else if (m_frame) begin
        if (acc) begin
          if (m_next == L - 1) begin
            m_frame = 1'b0;
            m_done  = 1'b1;
            m_next  = 0;
          end else begin
            m_next++;
          end
        end
      end else if (Start) begin
        m_frame = 1'b1;
        m_next  = 0;
      end
    end
    #1;
    check("out_bus", Out_Bus, model_bus());
    check("lane_full", {112'b0, Lane_Full}, {112'b0, model_full()});
    check("busy", {127'b0, Busy}, {127'b0, m_frame});
    check("frame_done", {127'b0, Frame_Done}, {127'b0, m_done});
    if (Frame_Done) done_pulses++;
  endtask

  task automatic put(input logic [S-1:0] sel, input logic [W-1:0] data);
    In_Sel   = sel;
    In_Data  = data;
    In_Valid = 1'b1;
    step();
    In_Valid = 1'b0;
  endtask

  initial begin
    logic [W*L-1:0] frame_exp;
    model_clear();
    quiet();
    In_Sel  = '0;
    In_Data = '0;

    // 1. Reset state
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    #1;
    check("rst_bus", Out_Bus, '0);
    check("rst_full", {112'b0, Lane_Full}, 128'h0);
    check("rst_ready", {127'b0, In_Ready}, 128'h1);
    check("rst_busy", {127'b0, Busy}, 128'h0);

    // 2. Direct write to lane 5, then a second write blocked by the full lane
    put(4'd5, 8'hA5);
    check("lane5_a5", {120'b0, Out_Bus[47:40]}, 128'hA5);
    check("full_0020", {112'b0, Lane_Full}, 128'h0020);
    In_Sel   = 4'd5;
    In_Data  = 8'h77;
    In_Valid = 1'b1;
    #1;
    check("blocked_ready", {127'b0, In_Ready}, 128'h0);
    step();
    In_Valid = 1'b0;
    check("lane5_held", {120'b0, Out_Bus[47:40]}, 128'hA5);

    // 3. Ack and write to the same lane in one cycle: write wins
    Lane_Ack = 16'h0020;
    put(4'd5, 8'h3C);
    Lane_Ack = '0;
    check("lane5_3c", {120'b0, Out_Bus[47:40]}, 128'h3C);
    check("full5_kept", {127'b0, Lane_Full[5]}, 128'h1);

    // Drain every lane before the frame test
    Lane_Ack = '1;
    step();
    Lane_Ack = '0;

    // 4. Auto frame of 16 bytes 0x10..0x1F
    done_pulses = 0;
    Start = 1'b1;
    step();
    Start = 1'b0;
    for (int i = 0; i < L; i++) begin
      In_Sel = 4'(L - 1 - i);
      put(4'd0, 8'(8'h10 + i));
      In_Sel = '0;
    end
    for (int i = 0; i < L; i++) frame_exp[i*W +: W] = 8'(8'h10 + i);
    check("frame_bus", Out_Bus, frame_exp);
    check("frame_full", {112'b0, Lane_Full}, 128'hFFFF);
    check("frame_done_hi", {127'b0, Frame_Done}, 128'h1);
    step();
    step();
    check("busy_after", {127'b0, Busy}, 128'h0);
    check("done_once", 128'(done_pulses), 128'd1);

    // 5. Stall on a full lane 3 inside a frame
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    put(4'd3, 8'h33);
    Start = 1'b1;
    step();
    Start = 1'b0;
    for (int i = 0; i < 3; i++) put(4'd9, 8'(8'h20 + i));
    In_Data  = 8'h99;
    In_Valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      Lane_Ack = (c == 3) ? 16'h0008 : 16'h0000;
      step();
      if (c < 3) begin
        check("stall_lane3", {120'b0, Out_Bus[31:24]}, 128'h33);
        check("stall_lane4", {120'b0, Out_Bus[39:32]}, 128'h00);
      end
    end
    In_Valid = 1'b0;
    Lane_Ack = '0;
    check("stall_landed", {120'b0, Out_Bus[31:24]}, 128'h99);
    put(4'd0, 8'h44);
    check("after_stall_lane4", {120'b0, Out_Bus[39:32]}, 128'h44);

    // 6. Reset mid-frame at counter 7, then refill from lane 0
    put(4'd0, 8'h55);
    put(4'd0, 8'h66);
    done_pulses = 0;
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    check("abort_bus", Out_Bus, '0);
    check("abort_full", {112'b0, Lane_Full}, 128'h0);
    check("abort_busy", {127'b0, Busy}, 128'h0);
    step();
    check("abort_no_done", 128'(done_pulses), 128'd0);
    Start = 1'b1;
    step();
    Start = 1'b0;
    put(4'd12, 8'hAB);
    check("refill_lane0", {120'b0, Out_Bus[7:0]}, 128'hAB);
    check("refill_busy", {127'b0, Busy}, 128'h1);

    // Randomized traffic; a stalled byte is held until accepted
    last_stall = 1'b0;
    In_Valid   = 1'b0;
    for (int n = 0; n < 600; n++) begin
      Rst      = ($urandom_range(79) == 0);
      Start    = ($urandom_range(7) == 0);
      Lane_Ack = 16'($urandom & $urandom & $urandom);
      if (!last_stall) begin
        In_Valid = $urandom_range(1);
        In_Sel   = 4'($urandom);
        In_Data  = 8'($urandom);
      end
      step();
      if (Rst) last_stall = 1'b0;
    end
    quiet();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
